mac_result_drain: RTL and testbench

- Output stage placed directly downstream of the 16-lane parallel MAC array.
- On a capture pulse it snapshots all lane results in a single cycle.
- It then serialises the results, one lane per beat, onto a valid/ready write stream toward the activation memory, generating an incrementing address per beat.
- The array can start the next accumulation immediately after capture while the drain is still in progress.

---
 rtl/mac_pkg.sv | 13 +
 rtl/mac_lane_snapshot.sv | 50 +++++
 rtl/mac_result_drain.sv | 153 +++++++++++++++
 tb/tb_mac_result_drain.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared defaults and types for the MAC result drain path.
package mac_pkg;

  localparam int MAC_NUM_LANES    = 16;
  localparam int MAC_OUTPUT_WIDTH = 16;
  localparam int LANE_IDX_W       = $clog2(MAC_NUM_LANES);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/mac_lane_snapshot.sv
// Lane snapshot register with optional ReLU at capture time and an indexed read port.
module mac_lane_snapshot import mac_pkg::*; #(
  parameter int NUM_LANES    = MAC_NUM_LANES,
  parameter int OUTPUT_WIDTH = MAC_OUTPUT_WIDTH,
  parameter int RELU_EN      = 0,
  parameter int IDX_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                              clk,
  input  logic                              arst_n_in,
  input  logic                              load,
  input  logic [NUM_LANES*OUTPUT_WIDTH-1:0] lanes_in,
  input  logic [IDX_W-1:0]                  rd_idx,
  output logic [OUTPUT_WIDTH-1:0]           rd_data
);

  logic [OUTPUT_WIDTH-1:0] snap_r [NUM_LANES];
  logic [OUTPUT_WIDTH-1:0] lane_s [NUM_LANES];

  function automatic logic [OUTPUT_WIDTH-1:0] relu_f(input logic [OUTPUT_WIDTH-1:0] v);
    if ((RELU_EN != 0) && v[OUTPUT_WIDTH-1]) begin
      relu_f = {OUTPUT_WIDTH{1'b0}};
    end else begin
      relu_f = v;
    end
  endfunction

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_unpack
    assign lane_s[g] = lanes_in[g*OUTPUT_WIDTH +: OUTPUT_WIDTH];
  end

  // Snapshot register: all lanes are loaded together on a capture.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < NUM_LANES; i++) snap_r[i] <= {OUTPUT_WIDTH{1'b0}};
    end else if (load) begin
      for (int i = 0; i < NUM_LANES; i++) snap_r[i] <= relu_f(lane_s[i]);
    end
  end

  // During a load the fresh lane bypasses the register so the first beat is ready next cycle.
  always_comb begin
    rd_data = {OUTPUT_WIDTH{1'b0}};
    if (load) begin
      rd_data = relu_f(lane_s[rd_idx]);
    end else begin
      rd_data = snap_r[rd_idx];
    end
  end

endmodule

// File: rtl/mac_result_drain.sv
// Captures the MAC array lane results and streams them one lane per beat with incrementing addresses.
module mac_result_drain import mac_pkg::*; #(
  parameter int NUM_LANES    = MAC_NUM_LANES,
  parameter int OUTPUT_WIDTH = MAC_OUTPUT_WIDTH,
  parameter int ADDR_WIDTH   = 16,
  parameter int RELU_EN      = 0
) (
  input  logic                              clk,
  input  logic                              arst_n_in,
  input  logic                              capture,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [NUM_LANES*OUTPUT_WIDTH-1:0] lanes_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUTPUT_WIDTH-1:0]           out_data,
  output logic [ADDR_WIDTH-1:0]             out_addr,
  output logic                              out_last,
  output logic                              busy,
  output logic                              capture_drop,
  input  logic                              clear_err
);

  localparam int               IDX_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

  drain_state_e            state_r, state_nxt_s;
  logic [IDX_W-1:0]        idx_r, idx_nxt_s;
  logic [ADDR_WIDTH-1:0]   base_r, base_nxt_s;
  logic                    load_s, drop_set_s, fire_s, valid_nxt_s;
  logic [OUTPUT_WIDTH-1:0] rd_data_s, data_nxt_s;
  logic [ADDR_WIDTH-1:0]   addr_nxt_s;
  logic                    out_valid_r, out_last_r, busy_r, drop_r;
  logic [OUTPUT_WIDTH-1:0] out_data_r;
  logic [ADDR_WIDTH-1:0]   out_addr_r;

  mac_lane_snapshot #(
    .NUM_LANES    (NUM_LANES),
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .RELU_EN      (RELU_EN),
    .IDX_W        (IDX_W)
  ) u_snapshot (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .load      (load_s),
    .lanes_in  (lanes_in),
    .rd_idx    (idx_nxt_s),
    .rd_data   (rd_data_s)
  );

  assign fire_s = out_valid_r && out_ready;

  // Next-state, lane index and capture acceptance.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    base_nxt_s  = base_r;
    load_s      = 1'b0;
    drop_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (capture) begin
          load_s      = 1'b1;
          state_nxt_s = ST_DRAIN;
          idx_nxt_s   = {IDX_W{1'b0}};
          base_nxt_s  = base_addr;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (fire_s && (idx_r == LAST_IDX)) begin
          idx_nxt_s = {IDX_W{1'b0}};
          if (capture) begin
            load_s      = 1'b1;
            state_nxt_s = ST_DRAIN;
            base_nxt_s  = base_addr;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          if (fire_s) begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end else begin
            idx_nxt_s = idx_r;
          end
          drop_set_s = capture;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Next beat contents; idle beats are zeroed.
  always_comb begin
    valid_nxt_s = (state_nxt_s == ST_DRAIN);
    data_nxt_s  = {OUTPUT_WIDTH{1'b0}};
    addr_nxt_s  = {ADDR_WIDTH{1'b0}};
    if (valid_nxt_s) begin
      data_nxt_s = rd_data_s;
      addr_nxt_s = base_nxt_s + ADDR_WIDTH'(idx_nxt_s);
    end else begin
      data_nxt_s = {OUTPUT_WIDTH{1'b0}};
      addr_nxt_s = {ADDR_WIDTH{1'b0}};
    end
  end

  // State, index and base registers.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      base_r  <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      base_r  <= base_nxt_s;
    end
  end

  // Registered stream outputs and the sticky drop flag (set beats clear).
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= {OUTPUT_WIDTH{1'b0}};
      out_addr_r  <= {ADDR_WIDTH{1'b0}};
      drop_r      <= 1'b0;
    end else begin
      out_valid_r <= valid_nxt_s;
      busy_r      <= valid_nxt_s;
      out_last_r  <= valid_nxt_s && (idx_nxt_s == LAST_IDX);
      out_data_r  <= data_nxt_s;
      out_addr_r  <= addr_nxt_s;
      if (drop_set_s) begin
        drop_r <= 1'b1;
      end else if (clear_err) begin
        drop_r <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_r;
  assign out_last     = out_last_r;
  assign busy         = busy_r;
  assign out_data     = out_data_r;
  assign out_addr     = out_addr_r;
  assign capture_drop = drop_r;

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: plain and ReLU instances share stimulus and are checked against a beat-queue model.
module tb_mac_result_drain;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] a;
    logic        l;
  } beat_t;

  logic         clk, arst_n_in, capture, out_ready, clear_err;
  logic [15:0]  base_addr;
  logic [255:0] lanes;
  logic         v0, l0, b0, dr0, v1, l1, b1, dr1;
  logic [15:0]  d0, a0, d1, a1;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t mq0[$], mq1[$], lg0[$], lg1[$];
  logic  m_drop;
  logic  hit;

  mac_result_drain #(.NUM_LANES(16), .OUTPUT_WIDTH(16), .ADDR_WIDTH(16), .RELU_EN(0)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .capture(capture), .base_addr(base_addr),
    .lanes_in(lanes), .out_valid(v0), .out_ready(out_ready), .out_data(d0),
    .out_addr(a0), .out_last(l0), .busy(b0), .capture_drop(dr0), .clear_err(clear_err));

  mac_result_drain #(.NUM_LANES(16), .OUTPUT_WIDTH(16), .ADDR_WIDTH(16), .RELU_EN(1)) dut_r (
    .clk(clk), .arst_n_in(arst_n_in), .capture(capture), .base_addr(base_addr),
    .lanes_in(lanes), .out_valid(v1), .out_ready(out_ready), .out_data(d1),
    .out_addr(a1), .out_last(l1), .busy(b1), .capture_drop(dr1), .clear_err(clear_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Model: a snapshot is just a queue of the beats still owed; capture loads it only when empty.
  always @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mq0.delete();
      mq1.delete();
      m_drop <= 1'b0;
    end else begin
      if (mq0.size() != 0 && out_ready) begin
        mq0.delete(0);
        mq1.delete(0);
      end
      if (capture) begin
        if (mq0.size() == 0) begin
          for (int i = 0; i < 16; i++) begin
            logic [15:0] v;
            v = lanes[i*16 +: 16];
            mq0.push_back({v, 16'(base_addr + 16'(i)), (i == 15)});
            mq1.push_back({(v[15] ? 16'h0000 : v), 16'(base_addr + 16'(i)), (i == 15)});
          end
        end else begin
          m_drop <= 1'b1;
        end
      end else if (clear_err) begin
        m_drop <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of accepted beats.
  always @(negedge clk) begin
    chk("valid0", v0, (mq0.size() != 0));
    chk("busy0", b0, (mq0.size() != 0));
    chk("drop0", dr0, m_drop);
    chk("valid1", v1, (mq1.size() != 0));
    chk("busy1", b1, (mq1.size() != 0));
    chk("drop1", dr1, m_drop);
    if (mq0.size() != 0) begin
      chk("data0", d0, mq0[0].d);
      chk("addr0", a0, mq0[0].a);
      chk("last0", l0, mq0[0].l);
      chk("data1", d1, mq1[0].d);
      chk("addr1", a1, mq1[0].a);
      chk("last1", l1, mq1[0].l);
    end
    if (v0 && out_ready) lg0.push_back({d0, a0, l0});
    if (v1 && out_ready) lg1.push_back({d1, a1, l1});
  end

  task automatic to_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_capture();
    capture = 1'b1;
    to_edge();
    capture = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (v0 && n < budget);
    chk("drain_timeout", v0, 1'b0);
  endtask

  task automatic set_ramp(input logic [15:0] base);
    for (int i = 0; i < 16; i++) lanes[i*16 +: 16] = 16'(i*3 - 20);
    base_addr = base;
  endtask

  initial begin
    arst_n_in = 1'b0; capture = 1'b0; out_ready = 1'b0; clear_err = 1'b0;
    base_addr = 16'h0000; lanes = '0;
    #1;
    chk("rst_valid", v0, 1'b0);
    chk("rst_busy", b0, 1'b0);
    chk("rst_last", l0, 1'b0);
    chk("rst_data", d0, 16'h0000);
    chk("rst_addr", a0, 16'h0000);
    chk("rst_drop", dr0, 1'b0);
    #22 arst_n_in = 1'b1;
    to_edge();

    // Basic drain
    set_ramp(16'h0100);
    out_ready = 1'b1;
    lg0.delete(); lg1.delete();
    pulse_capture();
    @(negedge clk);
    chk("latency_valid", v0, 1'b1);
    chk("first_data", d0, 16'hFFEC);
    chk("first_addr", a0, 16'h0100);
    wait_idle(40);
    chk("basic_count", lg0.size(), 16);
    chk("basic_d0", lg0[0].d, 16'hFFEC);
    chk("basic_d15", lg0[15].d, 16'd25);
    chk("basic_a15", lg0[15].a, 16'h010F);
    chk("basic_l15", lg0[15].l, 1'b1);
    chk("basic_l14", lg0[14].l, 1'b0);
    to_edge();

    // Backpressure 1,0,0,1
    lg0.delete(); lg1.delete();
    for (int c = 0; c < 80; c++) begin
      capture = (c == 0);
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      to_edge();
    end
    capture = 1'b0; out_ready = 1'b1;
    chk("bp_count", lg0.size(), 16);
    chk("bp_d7", lg0[7].d, 16'd1);
    chk("bp_a9", lg0[9].a, 16'h0109);

    // Back-to-back capture on the last transfer
    lg0.delete(); lg1.delete();
    pulse_capture();
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      hit = v0 && l0;
    end
    chk("b2b_last_seen", hit, 1'b1);
    for (int i = 0; i < 16; i++) lanes[i*16 +: 16] = 16'd7;
    base_addr = 16'h0200;
    capture = 1'b1;
    to_edge();
    capture = 1'b0;
    @(negedge clk);
    chk("b2b_valid", v0, 1'b1);
    chk("b2b_data", d0, 16'd7);
    chk("b2b_addr", a0, 16'h0200);
    wait_idle(40);
    chk("b2b_count", lg0.size(), 32);
    chk("b2b_drop", dr0, 1'b0);
    to_edge();

    // Dropped capture at beat 5 (with a coincident clear: set wins)
    set_ramp(16'h0300);
    lg0.delete(); lg1.delete();
    pulse_capture();
    repeat (5) to_edge();
    capture = 1'b1; clear_err = 1'b1;
    to_edge();
    capture = 1'b0; clear_err = 1'b0;
    chk("drop_set", dr0, 1'b1);
    wait_idle(40);
    chk("drop_count", lg0.size(), 16);
    chk("drop_d5", lg0[5].d, 16'hFFFB);
    chk("drop_a15", lg0[15].a, 16'h030F);
    chk("drop_held", dr0, 1'b1);
    to_edge();
    clear_err = 1'b1;
    to_edge();
    clear_err = 1'b0;
    chk("drop_clear", dr0, 1'b0);

    // ReLU and address wrap
    for (int i = 0; i < 16; i++) lanes[i*16 +: 16] = (i % 2 == 0) ? 16'hFFFF : 16'h7FFF;
    base_addr = 16'hFFF8;
    lg0.delete(); lg1.delete();
    pulse_capture();
    wait_idle(40);
    chk("relu_count", lg1.size(), 16);
    chk("relu_d0", lg1[0].d, 16'h0000);
    chk("relu_d1", lg1[1].d, 16'h7FFF);
    chk("relu_a7", lg1[7].a, 16'hFFFF);
    chk("relu_a8", lg1[8].a, 16'h0000);
    chk("relu_a15", lg1[15].a, 16'h0007);
    chk("norelu_d0", lg0[0].d, 16'hFFFF);
    to_edge();

    // Reset mid-drain
    set_ramp(16'h0400);
    pulse_capture();
    repeat (8) to_edge();
    #3 arst_n_in = 1'b0;
    #1;
    chk("arst_valid", v0, 1'b0);
    chk("arst_busy", b0, 1'b0);
    chk("arst_last", l0, 1'b0);
    chk("arst_valid_r", v1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 arst_n_in = 1'b1;
    lg0.delete(); lg1.delete();
    repeat (10) to_edge();
    chk("post_rst_beats", lg0.size(), 0);
    pulse_capture();
    wait_idle(40);
    chk("recover_count", lg0.size(), 16);
    chk("recover_a0", lg0[0].a, 16'h0400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
